// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//
// Conditions one raw, asynchronous, bouncing push-button into a clean
// registered level, and derives edge pulses plus an auto-repeat pulse train
// while the button is held.
//
// Ports:
//   i_clk      clock (single domain)
//   i_rst_n    synchronous active-low reset
//   i_btn      raw button input, asynchronous and possibly bouncing
//   o_level    debounced level (registered)
//   o_level_d  o_level delayed by one cycle (registered)
//   o_rise     one-cycle pulse, o_level & ~o_level_d
//   o_fall     one-cycle pulse, ~o_level & o_level_d
//   o_repeat   one-cycle auto-repeat pulse (registered)
//   o_held     high while the repeat FSM is in its repeating state
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned REPEAT_EN    = 1,
  parameter int unsigned REPEAT_DELAY = 10,
  parameter int unsigned REPEAT_RATE  = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_level_d,
  output logic o_rise,
  output logic o_fall,
  output logic o_repeat,
  output logic o_held
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] RPT_DELAY = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RPT_RATE  = CNT_W'(REPEAT_RATE);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StRepeat
  } state_e;

  // ---------------------------------------------------------------------------
  // Synchronizer and debounce
  // ---------------------------------------------------------------------------
  logic             r_sync1;
  logic             r_sync;
  logic             r_level;
  logic             r_level_d;
  logic [CNT_W-1:0] r_dcnt;

  logic             w_level_nxt;
  logic [CNT_W-1:0] w_dcnt_nxt;

  // The next debounced level is also needed by the repeat FSM, so that a
  // repeat pulse is never registered into the cycle in which the level drops.
  always_comb begin
    w_level_nxt = r_level;
    w_dcnt_nxt  = '0;
    if (r_sync != r_level) begin
      if (r_dcnt == DEB_LAST) begin
        w_level_nxt = r_sync;
      end else begin
        w_dcnt_nxt = r_dcnt + ONE;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1   <= 1'b0;
      r_sync    <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_dcnt    <= '0;
    end else begin
      r_sync1   <= i_btn;
      r_sync    <= r_sync1;
      r_level   <= w_level_nxt;
      r_level_d <= r_level;
      r_dcnt    <= w_dcnt_nxt;
    end
  end

  logic w_rise;
  logic w_fall;

  assign w_rise = r_level & ~r_level_d;
  assign w_fall = ~r_level & r_level_d;

  // ---------------------------------------------------------------------------
  // Auto-repeat FSM
  //
  // r_rcnt equals k in the k-th cycle after the rise cycle (WAIT) or after the
  // last terminal cycle (REPEAT). The terminal cycle is the one whose count
  // equals the delay/rate; r_repeat is registered one edge ahead so that it is
  // high exactly in that cycle, gated by the next level so a release wins.
  // ---------------------------------------------------------------------------
  state_e           r_state;
  logic [CNT_W-1:0] r_rcnt;
  logic             r_repeat;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_rcnt   <= '0;
      r_repeat <= 1'b0;
    end else begin
      r_repeat <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_rise && (REPEAT_EN != 0)) begin
            r_state <= StWait;
            r_rcnt  <= ONE;
          end
        end
        StWait: begin
          if (!r_level) begin
            r_state <= StIdle;
            r_rcnt  <= '0;
          end else if (r_rcnt == RPT_DELAY) begin
            r_state  <= StRepeat;
            r_rcnt   <= ONE;
            r_repeat <= w_level_nxt && (RPT_RATE == ONE);
          end else begin
            r_rcnt   <= r_rcnt + ONE;
            r_repeat <= w_level_nxt && ((r_rcnt + ONE) == RPT_DELAY);
          end
        end
        StRepeat: begin
          if (!r_level) begin
            r_state <= StIdle;
            r_rcnt  <= '0;
          end else if (r_rcnt == RPT_RATE) begin
            r_rcnt   <= ONE;
            r_repeat <= w_level_nxt && (RPT_RATE == ONE);
          end else begin
            r_rcnt   <= r_rcnt + ONE;
            r_repeat <= w_level_nxt && ((r_rcnt + ONE) == RPT_RATE);
          end
        end
        default: begin
          r_state <= StIdle;
          r_rcnt  <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_level   = r_level;
  assign o_level_d = r_level_d;
  assign o_rise    = w_rise;
  assign o_fall    = w_fall;
  assign o_repeat  = r_repeat;
  assign o_held    = (r_state == StRepeat);

endmodule

// File: tb/tb_btn_debounce.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce
//
// Three instances: defaults (u_dut0), repeat disabled (u_dut1), and minimum
// debounce with the shortest delay and a rate of one (u_dut2). Inputs change
// and outputs are sampled on the falling clock edge; cyc counts rising edges,
// so "cycle n" is the cycle following rising edge n.
// -----------------------------------------------------------------------------
module tb_btn_debounce;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0_n;
  logic       rst1_n;
  logic [2:0] btn;
  logic [2:0] level;
  logic [2:0] level_d;
  logic [2:0] rise;
  logic [2:0] fall;
  logic [2:0] rpt;
  logic [2:0] held;

  btn_debounce u_dut0 (
    .i_clk    (clk),
    .i_rst_n  (rst0_n),
    .i_btn    (btn[0]),
    .o_level  (level[0]),
    .o_level_d(level_d[0]),
    .o_rise   (rise[0]),
    .o_fall   (fall[0]),
    .o_repeat (rpt[0]),
    .o_held   (held[0])
  );

  btn_debounce #(
    .REPEAT_EN(0)
  ) u_dut1 (
    .i_clk    (clk),
    .i_rst_n  (rst1_n),
    .i_btn    (btn[1]),
    .o_level  (level[1]),
    .o_level_d(level_d[1]),
    .o_rise   (rise[1]),
    .o_fall   (fall[1]),
    .o_repeat (rpt[1]),
    .o_held   (held[1])
  );

  btn_debounce #(
    .DEBOUNCE_CYC(1),
    .REPEAT_DELAY(2),
    .REPEAT_RATE (1)
  ) u_dut2 (
    .i_clk    (clk),
    .i_rst_n  (rst1_n),
    .i_btn    (btn[2]),
    .o_level  (level[2]),
    .o_level_d(level_d[2]),
    .o_rise   (rise[2]),
    .o_fall   (fall[2]),
    .o_repeat (rpt[2]),
    .o_held   (held[2])
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  // Expected cycle numbers of u_dut0 pulses, pushed when a press/release is driven.
  int q_rise[$];
  int q_fall[$];
  int q_rep[$];

  int n1_rise = 0;
  int n1_fall = 0;
  int n1_rep  = 0;
  int n1_held = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Scoreboard for u_dut0: every pulse must match the next expected cycle.
  always @(negedge clk) begin
    if (rise[0] === 1'b1) begin
      if (q_rise.size() == 0) check("unexpected_rise", cyc, 32'hffff_ffff);
      else check("rise_cycle", cyc, q_rise.pop_front());
    end
    if (fall[0] === 1'b1) begin
      if (q_fall.size() == 0) check("unexpected_fall", cyc, 32'hffff_ffff);
      else check("fall_cycle", cyc, q_fall.pop_front());
    end
    if (rpt[0] === 1'b1) begin
      if (q_rep.size() == 0) check("unexpected_repeat", cyc, 32'hffff_ffff);
      else check("repeat_cycle", cyc, q_rep.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rise[1] === 1'b1) n1_rise++;
    if (fall[1] === 1'b1) n1_fall++;
    if (rpt[1] === 1'b1) n1_rep++;
    if (held[1] === 1'b1) n1_held++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int r;
    int t2;

    // 1: reset held with the button pressed, then a fresh press.
    btn    = 3'b001;
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs", {level[0], level_d[0], rise[0], fall[0], rpt[0], held[0]}, 6'b0);
    end
    rst0_n = 1'b1;
    rst1_n = 1'b1;
    t0 = cyc;
    q_rise.push_back(t0 + 6);
    wait_cyc(t0 + 5);
    check("t1_level_before", level[0], 1'b0);
    wait_cyc(t0 + 6);
    check("t1_level_edge6", level[0], 1'b1);
    check("t1_rise", rise[0], 1'b1);
    check("t1_level_d_lag", level_d[0], 1'b0);
    btn[0] = 1'b0;
    q_fall.push_back(t0 + 12);
    wait_cyc(t0 + 7);
    check("t1_rise_one_cycle", rise[0], 1'b0);
    check("t1_level_d", level_d[0], 1'b1);
    wait_cyc(t0 + 13);
    check("t1_level_low", level[0], 1'b0);
    check("t1_fall_one_cycle", fall[0], 1'b0);

    // 2: single-cycle toggling, then 3-cycle high glitches: never a level change.
    wait_cyc(t0 + 16);
    for (int i = 0; i < 6; i++) begin
      btn[0] = (i % 2 == 0);
      @(negedge clk);
    end
    btn[0] = 1'b0;
    repeat (10) @(negedge clk);
    check("t2_toggle_level", level[0], 1'b0);
    for (int k = 0; k < 3; k++) begin
      btn[0] = 1'b1;
      repeat (3) @(negedge clk);
      btn[0] = 1'b0;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check("t2_glitch_level", level[0], 1'b0);

    // 3: long hold with a short low glitch early on; release lands at R+24.
    t0 = cyc;
    btn[0] = 1'b1;
    r = t0 + 6;
    q_rise.push_back(r);
    for (int k = 0; k < 5; k++) q_rep.push_back(r + 10 + 3 * k);
    q_fall.push_back(r + 24);
    wait_cyc(r + 1);
    btn[0] = 1'b0;
    wait_cyc(r + 4);
    btn[0] = 1'b1;
    wait_cyc(r + 10);
    check("t3_first_repeat", rpt[0], 1'b1);
    check("t3_held_not_yet", held[0], 1'b0);
    wait_cyc(r + 11);
    check("t3_held_on", held[0], 1'b1);
    check("t3_repeat_gap", rpt[0], 1'b0);
    wait_cyc(r + 18);
    btn[0] = 1'b0;
    wait_cyc(r + 24);
    check("t3_level_fell", level[0], 1'b0);
    check("t3_held_fall_cycle", held[0], 1'b1);
    wait_cyc(r + 25);
    check("t3_held_off", held[0], 1'b0);
    check("t3_no_repeat_after", rpt[0], 1'b0);

    // 4a: release lands exactly on the first due repeat (still in WAIT).
    wait_cyc(r + 30);
    t0 = cyc;
    btn[0] = 1'b1;
    r = t0 + 6;
    q_rise.push_back(r);
    q_fall.push_back(r + 10);
    wait_cyc(r + 4);
    btn[0] = 1'b0;
    wait_cyc(r + 10);
    check("t4a_fall", fall[0], 1'b1);
    check("t4a_no_repeat", rpt[0], 1'b0);
    wait_cyc(r + 11);
    check("t4a_held_off", held[0], 1'b0);

    // 4b: release lands on a due repeat while repeating.
    wait_cyc(r + 16);
    t0 = cyc;
    btn[0] = 1'b1;
    r = t0 + 6;
    q_rise.push_back(r);
    q_rep.push_back(r + 10);
    q_fall.push_back(r + 13);
    wait_cyc(r + 7);
    btn[0] = 1'b0;
    wait_cyc(r + 12);
    check("t4b_held_before", held[0], 1'b1);
    wait_cyc(r + 13);
    check("t4b_fall", fall[0], 1'b1);
    check("t4b_no_repeat", rpt[0], 1'b0);
    wait_cyc(r + 14);
    check("t4b_held_off", held[0], 1'b0);

    // 5: reset while repeating with the button still held.
    wait_cyc(r + 20);
    t0 = cyc;
    btn[0] = 1'b1;
    r = t0 + 6;
    q_rise.push_back(r);
    q_rep.push_back(r + 10);
    q_rep.push_back(r + 13);
    wait_cyc(r + 14);
    check("t5_held_before_rst", held[0], 1'b1);
    rst0_n = 1'b0;
    wait_cyc(r + 15);
    check("t5_rst_outputs", {level[0], level_d[0], rise[0], fall[0], rpt[0], held[0]}, 6'b0);
    wait_cyc(r + 16);
    check("t5_rst_outputs2", {level[0], level_d[0], rise[0], fall[0], rpt[0], held[0]}, 6'b0);
    rst0_n = 1'b1;
    t2 = cyc;
    q_rise.push_back(t2 + 6);
    wait_cyc(t2 + 5);
    check("t5_level_before", level[0], 1'b0);
    wait_cyc(t2 + 6);
    check("t5_fresh_rise", rise[0], 1'b1);
    btn[0] = 1'b0;
    q_fall.push_back(t2 + 12);
    wait_cyc(t2 + 14);

    // 6a: repeat disabled, 40-cycle hold.
    t0 = cyc;
    btn[1] = 1'b1;
    wait_cyc(t0 + 6);
    check("t6_noen_level", level[1], 1'b1);
    wait_cyc(t0 + 40);
    btn[1] = 1'b0;
    wait_cyc(t0 + 52);
    check("t6_noen_rises", n1_rise, 1);
    check("t6_noen_falls", n1_fall, 1);
    check("t6_noen_repeats", n1_rep, 0);
    check("t6_noen_held", n1_held, 0);

    // 6b: DEBOUNCE_CYC=1, REPEAT_DELAY=2, REPEAT_RATE=1.
    t0 = cyc;
    btn[2] = 1'b1;
    r = t0 + 3;
    wait_cyc(t0 + 2);
    check("t6_d1_level_before", level[2], 1'b0);
    wait_cyc(r);
    check("t6_d1_level_edge3", level[2], 1'b1);
    check("t6_d1_rise", rise[2], 1'b1);
    wait_cyc(r + 1);
    check("t6_d1_r1", {rpt[2], held[2]}, 2'b00);
    wait_cyc(r + 2);
    check("t6_d1_r2", {rpt[2], held[2]}, 2'b10);
    btn[2] = 1'b0;
    wait_cyc(r + 3);
    check("t6_d1_r3", {rpt[2], held[2]}, 2'b11);
    wait_cyc(r + 4);
    check("t6_d1_r4", {rpt[2], held[2]}, 2'b11);
    wait_cyc(r + 5);
    check("t6_d1_r5", {fall[2], rpt[2], held[2]}, 3'b101);
    wait_cyc(r + 6);
    check("t6_d1_r6", {fall[2], rpt[2], held[2]}, 3'b000);

    // Every expected u_dut0 pulse must have been consumed.
    check("rise_q_empty", q_rise.size(), 0);
    check("fall_q_empty", q_fall.size(), 0);
    check("repeat_q_empty", q_rep.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
